// File: rtl/priority_req_capture_if.sv
// Request/grant bundle between capture stage and its neighbours.
// Master drives requests/ack; slave (the capture stage) drives grants.
interface priority_req_capture_if #(
    parameter int DROP_CNT_W = 4
);
    logic                  req_a;
    logic                  req_b;
    logic                  req_c;
    logic                  ack;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  gnt_c;
    logic                  valid;
    logic [2:0]            pend;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output req_a, req_b, req_c, ack,
        input  gnt_a, gnt_b, gnt_c, valid, pend, drop_cnt
    );

    modport slave (
        input  req_a, req_b, req_c, ack,
        output gnt_a, gnt_b, gnt_c, valid, pend, drop_cnt
    );
endinterface

// File: rtl/priority_req_capture.sv
// Sticky request capture with one-at-a-time held grant and drop counter.
// Define PRIORITY_REQ_RR_EN for round-robin instead of fixed a>b>c.
module priority_req_capture #(
    parameter int DROP_CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    priority_req_capture_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam int SW = DROP_CNT_W + 2;
    localparam logic [SW-1:0] DROP_MAX = SW'({DROP_CNT_W{1'b1}});

    logic [0:0]            r_state;
    logic [2:0]            r_pend;
    logic [2:0]            r_gnt;
    logic [DROP_CNT_W-1:0] r_drop;

    logic [2:0]    w_req;
    logic          w_acked;
    logic [2:0]    w_clr;
    logic [2:0]    w_coal;
    logic [1:0]    w_ncoal;
    logic [SW-1:0] w_sum;
    logic [2:0]    w_pick;

    assign w_req   = {bus.req_c, bus.req_b, bus.req_a};
    assign w_acked = (r_state == GRANT) & bus.ack;
    assign w_clr   = w_acked ? r_gnt : 3'b000;
    // A request on the channel being cleared re-arms it; not a drop.
    assign w_coal  = w_req & r_pend & ~w_clr;
    assign w_ncoal = 2'(w_coal[0]) + 2'(w_coal[1])
                   + 2'(w_coal[2]);
    assign w_sum   = SW'(r_drop) + SW'(w_ncoal);

`ifdef PRIORITY_REQ_RR_EN
    logic [1:0] r_last;

    always_comb begin
        w_pick = 3'b000;
        case (r_last)
            2'd0: begin
                if (r_pend[1])      w_pick = 3'b010;
                else if (r_pend[2]) w_pick = 3'b100;
                else if (r_pend[0]) w_pick = 3'b001;
            end
            2'd1: begin
                if (r_pend[2])      w_pick = 3'b100;
                else if (r_pend[0]) w_pick = 3'b001;
                else if (r_pend[1]) w_pick = 3'b010;
            end
            default: begin
                if (r_pend[0])      w_pick = 3'b001;
                else if (r_pend[1]) w_pick = 3'b010;
                else if (r_pend[2]) w_pick = 3'b100;
            end
        endcase
    end

    // Pointer starts at "c served" so the first search is a>b>c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 2'd2;
        end else if (w_acked) begin
            if (r_gnt[0])      r_last <= 2'd0;
            else if (r_gnt[1]) r_last <= 2'd1;
            else               r_last <= 2'd2;
        end
    end
`else
    always_comb begin
        w_pick = 3'b000;
        if (r_pend[0])      w_pick = 3'b001;
        else if (r_pend[1]) w_pick = 3'b010;
        else if (r_pend[2]) w_pick = 3'b100;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 3'b000;
            r_drop <= '0;
        end else begin
            r_pend <= w_req | (r_pend & ~w_clr);
            if (w_sum > DROP_MAX)
                r_drop <= DROP_MAX[DROP_CNT_W-1:0];
            else
                r_drop <= w_sum[DROP_CNT_W-1:0];
        end
    end

    // Grant loads from registered pend only, so same-cycle requests wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pend != 3'b000) begin
                        r_gnt   <= w_pick;
                        r_state <= GRANT;
                    end
                end
                default: begin
                    if (bus.ack) begin
                        r_gnt   <= 3'b000;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.gnt_a    = r_gnt[0];
    assign bus.gnt_b    = r_gnt[1];
    assign bus.gnt_c    = r_gnt[2];
    assign bus.valid    = (r_state == GRANT);
    assign bus.pend     = r_pend;
    assign bus.drop_cnt = r_drop;
endmodule

// File: tb/tb_priority_req_capture.sv
// Bench for priority_req_capture: directed literals plus random
// stimulus compared every cycle against a behavioural model.
module tb_priority_req_capture;
    localparam int W = 4;
    localparam int DMAX = (1 << W) - 1;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    priority_req_capture_if #(.DROP_CNT_W(W)) bus ();

    priority_req_capture #(.DROP_CNT_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: pending flags, granted channel index (-1 = none).
    bit m_p[3];
    int m_g;
    int m_drop;
    int m_last;

    function automatic int choose();
        int j;
        for (int k = 1; k <= 3; k++) begin
            j = (m_last + k) % 3;
            if (m_p[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit r[3];
        bit np[3];
        bit clr;
        int n;
        if (!rst_n) begin
            m_p = '{0, 0, 0};
            m_g = -1;
            m_drop = 0;
            m_last = 2;
        end else begin
            r = '{bus.req_a, bus.req_b, bus.req_c};
            n = 0;
            for (int i = 0; i < 3; i++) begin
                clr = (m_g == i) && bus.ack;
                if (r[i] && m_p[i] && !clr) n++;
                np[i] = r[i] || (m_p[i] && !clr);
            end
            if (m_g < 0) begin
                m_g = choose();
            end else if (bus.ack) begin
`ifdef PRIORITY_REQ_RR_EN
                m_last = m_g;
`endif
                m_g = -1;
            end
            m_p = np;
            m_drop = (m_drop + n > DMAX) ? DMAX : m_drop + n;
        end
    end

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [2:0] gnts();
        return {bus.gnt_c, bus.gnt_b, bus.gnt_a};
    endfunction

    always @(negedge clk) begin
        logic [2:0] ep;
        logic [2:0] eg;
        if (rst_n) begin
            ep = {m_p[2], m_p[1], m_p[0]};
            eg = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
            chk("m_pend", 32'(bus.pend), 32'(ep));
            chk("m_gnt", 32'(gnts()), 32'(eg));
            chk("m_valid", 32'(bus.valid), 32'(m_g >= 0));
            chk("m_drop", 32'(bus.drop_cnt), 32'(m_drop));
        end
    end

    task automatic drv(bit ra, bit rb, bit rc, bit ak);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.req_c = rc;
        bus.ack   = ak;
    endtask

    task automatic cyc(bit ra, bit rb, bit rc, bit ak);
        drv(ra, rb, rc, ak);
        @(negedge clk);
    endtask

    task automatic wait_grant(string nm, logic [2:0] eg);
        int k = 0;
        drv(0, 0, 0, 0);
        while (!bus.valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid"}, 32'(bus.valid), 1);
        chk({nm, "_gnt"}, 32'(gnts()), 32'(eg));
    endtask

    task automatic do_ack(string nm);
        cyc(0, 0, 0, 1);
        drv(0, 0, 0, 0);
        chk({nm, "_ackvalid"}, 32'(bus.valid), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk("rst_pend", 32'(bus.pend), 0);
            chk("rst_valid", 32'(bus.valid), 0);
            chk("rst_gnt", 32'(gnts()), 0);
            chk("rst_drop", 32'(bus.drop_cnt), 0);
        end

        cyc(1, 1, 1, 0);
        chk("sim_pend", 32'(bus.pend), 32'h7);
        wait_grant("sim_a", 3'b001);
        do_ack("sim_a");
        wait_grant("sim_b", 3'b010);
        do_ack("sim_b");
        wait_grant("sim_c", 3'b100);
        do_ack("sim_c");
        @(negedge clk);

        cyc(0, 1, 0, 0);
        chk("one_pend", 32'(bus.pend), 32'h2);
        chk("one_valid0", 32'(bus.valid), 0);
        cyc(0, 0, 0, 0);
        chk("one_valid1", 32'(bus.valid), 1);
        chk("one_gnt", 32'(gnts()), 32'h2);
        cyc(0, 0, 0, 1);
        chk("one_done", 32'(bus.valid), 0);
        chk("one_clr", 32'(bus.pend), 0);

        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("pri_gnt_c", 32'(gnts()), 32'h4);
        cyc(1, 0, 0, 0);
        chk("pri_hold1", 32'(gnts()), 32'h4);
        chk("pri_pend", 32'(bus.pend), 32'h5);
        cyc(0, 0, 0, 0);
        chk("pri_hold2", 32'(gnts()), 32'h4);
        cyc(0, 0, 0, 1);
        chk("pri_idle", 32'(bus.valid), 0);
        chk("pri_pend_a", 32'(bus.pend), 32'h1);
        cyc(0, 0, 0, 0);
        chk("pri_gnt_a", 32'(gnts()), 32'h1);
        do_ack("pri_a");
        @(negedge clk);

        cyc(1, 0, 0, 0);
        wait_grant("soc", 3'b001);
        cyc(1, 0, 0, 1);
        chk("soc_pend", 32'(bus.pend), 32'h1);
        chk("soc_drop", 32'(bus.drop_cnt), 0);
        chk("soc_idle", 32'(bus.valid), 0);
        cyc(0, 0, 0, 0);
        chk("soc_regnt", 32'(gnts()), 32'h1);
        do_ack("soc");
        @(negedge clk);

        cyc(1, 0, 0, 0);
        repeat (20) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("coal_sat", 32'(bus.drop_cnt), 32'(DMAX));
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("coal_hold", 32'(bus.drop_cnt), 32'(DMAX));
        chk("coal_gnt", 32'(gnts()), 32'h1);
        do_ack("coal");
        @(negedge clk);

        cyc(0, 1, 0, 0);
        wait_grant("mid", 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(bus.valid), 0);
        chk("mid_gnt", 32'(gnts()), 0);
        chk("mid_pend", 32'(bus.pend), 0);
        chk("mid_drop", 32'(bus.drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("mid_after", 32'(bus.valid), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1);
        end
        drv(0, 0, 0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
